// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one add_sub_logic unit between two
// requesters. The winner's operands are latched, evaluated for one cycle, and
// the registered result is returned through a valid/ready handshake.
//
// add_sub_logic opcodes:
//   0: a + b
//   1: a - b
//   2: a ^ b
//   3: a >= b (unsigned, i.e. the carry out of a - b), zero-extended

module add_sub_logic #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned OPW   = 2
) (
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r
);

  // Pure combinational arithmetic; results wrap to WIDTH bits.
  always_comb begin
    r = '0;
    case (op)
      OPW'(0): r = a + b;
      OPW'(1): r = a - b;
      OPW'(2): r = a ^ b;
      OPW'(3): r = WIDTH'(a >= b);
      default: r = '0;
    endcase
  end

endmodule

module alu_share_arbiter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned OPW   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp_valid,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_r,
  input  logic             resp_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  logic             resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_r_q, resp_r_d;

  logic             win_id;
  logic             accept;
  logic [WIDTH-1:0] alu_r;

  add_sub_logic #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_alu (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .r  (alu_r)
  );

  // Round-robin winner: a lone requester wins; on a tie the one not granted last.
  // Ready is also gated by rst_n so both readies drop the instant reset asserts.
  always_comb begin
    win_id     = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    accept     = rst_n && (state_q == IDLE) && (req0_valid || req1_valid);
    req0_ready = accept && !win_id;
    req1_ready = accept && win_id;
  end

  // Next-state logic: accept in IDLE, one evaluation cycle, then hold the result.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    resp_id_d    = resp_id_q;
    resp_r_d     = resp_r_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          id_d         = win_id;
          last_grant_d = win_id;
          op_d         = win_id ? req1_op : req0_op;
          a_d          = win_id ? req1_a  : req0_a;
          b_d          = win_id ? req1_b  : req0_b;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        resp_r_d  = alu_r;
        resp_id_d = id_q;
        state_d   = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_r_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      resp_id_q    <= resp_id_d;
      resp_r_q     <= resp_r_d;
    end
  end

  // Response valid is exactly the RESP state, so it is a registered signal.
  always_comb begin
    resp_valid = (state_q == RESP);
    resp_id    = resp_id_q;
    resp_r     = resp_r_q;
    busy       = (state_q != IDLE);
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational add_sub_logic unit (2-bit op, 16-bit a/b, 16-bit r) between two requesters.
- Arbitrates round-robin, latches the winner's operands, and presents them to the unit for one cycle.
- Registers the result and returns it to the winning requester through a valid/ready handshake.
- Sits between the two instruction-issue front ends and the single shared ALU instance it contains.

Parameters:
- WIDTH, 16, operand/result width; must match the instantiated add_sub_logic.
- OPW, 2, opcode width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_op  input  OPW  requester 0 opcode.
- req0_a, req0_b  input  WIDTH  requester 0 operands.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1.
- resp_valid  output  1  result available.
- resp_id  output  1  requester that owns the result.
- resp_r  output  WIDTH  registered result.
- resp_ready  input  1  consumer takes result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low, any time, asynchronous):
  - state=IDLE, last_grant=1 (requester 0 wins the first tie).
  - req0_ready=0, req1_ready=0, resp_valid=0, resp_id=0, resp_r=0, busy=0.
  - Latched op/a/b cleared to 0.
  - Reset mid-operation discards the in-flight op; no response is produced for it.
- States: IDLE, EXEC, RESP.
- IDLE:
  - req*_ready are combinational: reqN_ready=1 only for the arbitration winner, only while in IDLE.
  - Only one valid: that requester wins.
  - Both valid: winner is the requester not equal to last_grant.
  - On a handshake edge (valid and ready both high): latch op/a/b/id, set last_grant=id, go to EXEC.
  - No valid: stay in IDLE.
- EXEC (exactly 1 cycle):
  - Latched op/a/b drive add_sub_logic.
  - At the edge: resp_r<=r, resp_id<=latched id, resp_valid<=1, go to RESP.
- RESP:
  - resp_valid=1; resp_r and resp_id held stable until handshake.
  - resp_ready=1 at an edge: resp_valid<=0, go to IDLE.
  - No new request is accepted in EXEC or RESP; both ready outputs are 0.
- Latency: handshake edge -> resp_valid high after 2 edges. Minimum issue interval is 3 cycles with resp_ready held high.
- Requester changes to op/a/b after acceptance have no effect on the in-flight result.
- Arithmetic: result is exactly the unit's r, truncated to WIDTH. The controller adds no sign or width handling.
- Fairness:
  - A continuously-valid requester is served at least every second grant.
  - last_grant updates only on acceptance, not on idle cycles.
- resp_ready high in IDLE or EXEC is ignored.

Test Plan:
- Reset: rst_n=0 mid-EXEC (req0 op=0, a=2, b=3 accepted) -> all outputs 0 immediately, asynchronously. After release, state=IDLE and no response appears.
- Single requester: req0 op=0, a=100, b=200, resp_ready=1 -> req0_ready=1 in the accept cycle; 2 edges later resp_valid=1, resp_id=0, resp_r=300 for one cycle.
- Subtract wrap: req1 op=1, a=100, b=200 -> resp_id=1, resp_r=16'hff9c.
- Contention: both valid continuously from reset; req0 op=1, a=10, b=5; req1 op=3, a=10, b=3; resp_ready=1.
  - Grant order must be 0,1,0,1.
  - Responses alternate r=5 (id 0) and r=1 (id 1).
- Backpressure: resp_ready=0 for 5 cycles after resp_valid rises (req0 op=3, a=3, b=10).
  - resp_r=0 and resp_id=0 hold stable; both ready outputs stay 0; req1 stays pending.
  - Raising resp_ready returns to IDLE and req1 is granted next cycle.
- Operand isolation: change req0_a from 2 to 7 the cycle after acceptance (op=0, b=3) -> resp_r=5.
